// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter slice.
// Build option: DMEM_ARB_RR_EN selects round-robin arbitration (default: CPU priority).
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_DMA = 1'b1
    } gnt_e;

    localparam int unsigned WAIT_CYCLES_DEFAULT = 2;
    localparam logic [31:0] ADDR_BASE_DEFAULT   = 32'd1024;
    localparam int unsigned DEPTH_DEFAULT       = 64;
    localparam int unsigned WAIT_W              = 4;

    // Word index of a byte address relative to the memory base; low two bits dropped.
    function automatic logic [31:0] word_index(input logic [31:0] addr,
                                               input logic [31:0] base);
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/dmem_arbiter_array.sv
// Data-memory word array: synchronous write, asynchronous read, whole array cleared on rst.
module dmem_array
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    // Word storage with asynchronous clear and single write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (CPU / DMA) arbiter in front of a wait-stated data memory.
// Build option: DMEM_ARB_RR_EN -- round-robin on simultaneous requests;
// undefined, the CPU always wins a tie and no last-grant register exists.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT,
    parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEFAULT,
    parameter int unsigned DEPTH       = DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic [31:0] dma_rdata,
    output logic        dma_ack,
    output logic        err,
    output logic        busy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    gnt_e                gnt_q, gnt_d;
    logic                we_q, we_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
`ifdef DMEM_ARB_RR_EN
    gnt_e                last_q, last_d;
`endif

    gnt_e                pick;
    logic [31:0]         idx;
    logic                oor;
    logic                mem_we;
    logic [31:0]         mem_rdata;
    logic                resp;

    assign idx = word_index(addr_q, ADDR_BASE);
    assign oor = (addr_q < ADDR_BASE) || (idx >= DEPTH);

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (mem_we),
        .addr_i  (idx[AW-1:0]),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

    // Requester chosen when leaving IDLE.
    always_comb begin
`ifdef DMEM_ARB_RR_EN
        if (cpu_req && dma_req) begin
            pick = (last_q == GNT_DMA) ? GNT_CPU : GNT_DMA;
        end else if (cpu_req) begin
            pick = GNT_CPU;
        end else begin
            pick = GNT_DMA;
        end
`else
        pick = cpu_req ? GNT_CPU : GNT_DMA;
`endif
    end

    // Next-state, transaction latch, wait countdown and memory strobe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
`ifdef DMEM_ARB_RR_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (cpu_req || dma_req) begin
                    state_d = ST_ACCESS;
                    cnt_d   = WAIT_W'(WAIT_CYCLES);
                    gnt_d   = pick;
                    we_d    = (pick == GNT_CPU) ? cpu_we    : dma_we;
                    addr_d  = (pick == GNT_CPU) ? cpu_addr  : dma_addr;
                    wdata_d = (pick == GNT_CPU) ? cpu_wdata : dma_wdata;
`ifdef DMEM_ARB_RR_EN
                    last_d  = pick;
`endif
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    mem_we  = we_q & ~oor;
                    rdata_d = (we_q || oor) ? '0 : mem_rdata;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                rdata_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and transaction registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gnt_q   <= GNT_CPU;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef DMEM_ARB_RR_EN
            last_q  <= GNT_DMA;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef DMEM_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    assign resp      = (state_q == ST_RESP);
    assign cpu_ack   = resp && (gnt_q == GNT_CPU);
    assign dma_ack   = resp && (gnt_q == GNT_DMA);
    assign err       = resp && oor;
    assign cpu_rdata = cpu_ack ? rdata_q : '0;
    assign dma_rdata = dma_ack ? rdata_q : '0;
    assign busy      = (state_q != ST_IDLE);
    assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dmem_arbiter;

    localparam int unsigned WAIT  = 2;
    localparam logic [31:0] BASE  = 32'd1024;
    localparam int unsigned DEPTH = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cpu_req, cpu_we, cpu_ack, cpu_stall;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_ack;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        err, busy;

    logic        z_cpu_ack, z_cpu_stall, z_dma_req, z_dma_ack, z_err, z_busy;
    logic [31:0] z_cpu_rdata, z_dma_rdata;

    dmem_arbiter #(
        .WAIT_CYCLES (WAIT),
        .ADDR_BASE   (BASE),
        .DEPTH       (DEPTH)
    ) u_dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack), .err(err), .busy(busy)
    );

    dmem_arbiter #(
        .WAIT_CYCLES (0),
        .ADDR_BASE   (BASE),
        .DEPTH       (DEPTH)
    ) u_dut0 (
        .clk(clk), .rst(rst),
        .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr(32'd0), .cpu_wdata(32'd0),
        .cpu_rdata(z_cpu_rdata), .cpu_ack(z_cpu_ack), .cpu_stall(z_cpu_stall),
        .dma_req(z_dma_req), .dma_we(1'b0), .dma_addr(BASE), .dma_wdata(32'd0),
        .dma_rdata(z_dma_rdata), .dma_ack(z_dma_ack), .err(z_err), .busy(z_busy)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: one transaction in flight, acked WAIT+2 cycles after sampling.
    logic [31:0] mmem [DEPTH];
    bit          m_active, m_gnt_dma, m_we, m_last_dma;
    int          m_rem;
    logic [31:0] m_addr, m_wdata;
    bit          e_cpu_ack, e_dma_ack;

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= BASE) && (((a - BASE) >> 2) < DEPTH);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) mmem[i] = '0;
        m_active   = 1'b0;
        m_rem      = 0;
        m_last_dma = 1'b1;
    endtask

    // Compare all outputs for the current cycle, then move the model across the next edge.
    task automatic step();
        bit          ack_now;
        logic [31:0] rd;
        if (rst) model_reset();
        ack_now = m_active && (m_rem == 0);
        rd = '0;
        if (ack_now && in_rng(m_addr)) begin
            if (m_we) mmem[widx(m_addr)] = m_wdata;
            else      rd = mmem[widx(m_addr)];
        end
        e_cpu_ack = ack_now && !m_gnt_dma;
        e_dma_ack = ack_now && m_gnt_dma;
        check32("busy",      {31'd0, busy},      {31'd0, m_active});
        check32("cpu_ack",   {31'd0, cpu_ack},   {31'd0, e_cpu_ack});
        check32("dma_ack",   {31'd0, dma_ack},   {31'd0, e_dma_ack});
        check32("err",       {31'd0, err},       {31'd0, ack_now && !in_rng(m_addr)});
        check32("cpu_rdata", cpu_rdata,          e_cpu_ack ? rd : 32'd0);
        check32("dma_rdata", dma_rdata,          e_dma_ack ? rd : 32'd0);
        check32("cpu_stall", {31'd0, cpu_stall}, {31'd0, cpu_req && !e_cpu_ack});
        if (!rst) begin
            if (!m_active) begin
                if (cpu_req || dma_req) begin
`ifdef DMEM_ARB_RR_EN
                    if (cpu_req && dma_req) m_gnt_dma = !m_last_dma;
                    else                    m_gnt_dma = !cpu_req;
                    m_last_dma = m_gnt_dma;
`else
                    m_gnt_dma = !cpu_req;
`endif
                    m_we     = m_gnt_dma ? dma_we    : cpu_we;
                    m_addr   = m_gnt_dma ? dma_addr  : cpu_addr;
                    m_wdata  = m_gnt_dma ? dma_wdata : cpu_wdata;
                    m_active = 1'b1;
                    m_rem    = int'(WAIT) + 1;
                end
            end else if (m_rem == 0) begin
                m_active = 1'b0;
            end else begin
                m_rem--;
            end
        end
    endtask

    task automatic tick();
        #1 step();
        @(negedge clk);
    endtask

    // One directed access on a single port; returns observed latency, data and err.
    task automatic txn(input bit dma, input bit we, input logic [31:0] addr,
                       input logic [31:0] data, output int lat,
                       output logic [31:0] rd, output logic er);
        lat = -1; rd = '0; er = 1'b0;
        if (dma) begin dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = data; end
        else     begin cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = data; end
        for (int c = 0; c < 20 && lat < 0; c++) begin
            #1 step();
            if (dma ? dma_ack : cpu_ack) begin
                lat = c;
                rd  = dma ? dma_rdata : cpu_rdata;
                er  = err;
            end
            @(negedge clk);
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        tick();
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(9, 0);
        if (r < 8)       return BASE + 32'(4 * $urandom_range(7, 0)) + 32'($urandom_range(3, 0));
        else if (r == 8) return BASE - 32'(4 * $urandom_range(4, 1));
        else             return BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(8, 0));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        er;
        int          acks;
        int          seq[$];
        int          exp_seq[3];

        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        z_dma_req = 0;
        model_reset();
        @(negedge clk);
        tick();
        tick();
        check32("rst_busy",  {31'd0, busy},    32'd0);
        check32("rst_ack",   {31'd0, cpu_ack | dma_ack | err}, 32'd0);
        check32("rst_rdata", cpu_rdata | dma_rdata, 32'd0);
        rst = 1'b0;
        tick();

        // Write then read back one word.
        txn(0, 1, 32'd1028, 32'hDEADBEEF, lat, rd, er);
        check32("wr_latency", 32'(lat), 32'd4);
        check32("wr_err", {31'd0, er}, 32'd0);
        txn(0, 0, 32'd1028, 32'd0, lat, rd, er);
        check32("rd_latency", 32'(lat), 32'd4);
        check32("rd_data", rd, 32'hDEADBEEF);
        txn(1, 0, 32'd1030, 32'd0, lat, rd, er);
        check32("dma_rd_data", rd, 32'hDEADBEEF);

        // Out-of-range accesses.
        txn(0, 0, 32'd1020, 32'd0, lat, rd, er);
        check32("oor_low_err", {31'd0, er}, 32'd1);
        check32("oor_low_rdata", rd, 32'd0);
        txn(0, 1, 32'd1280, 32'h12345678, lat, rd, er);
        check32("oor_wr_err", {31'd0, er}, 32'd1);
        txn(0, 0, 32'd1280, 32'd0, lat, rd, er);
        check32("oor_high_err", {31'd0, er}, 32'd1);
        check32("oor_high_rdata", rd, 32'd0);
        txn(0, 0, 32'd1024, 32'd0, lat, rd, er);
        check32("word0_untouched", rd, 32'd0);
        check32("word0_err", {31'd0, er}, 32'd0);

        // Reset while the write sits in ACCESS.
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'd1032; cpu_wdata = 32'hCAFEF00D;
        tick();
        tick();
        rst = 1'b1; cpu_req = 1'b0;
        tick();
        rst = 1'b0;
        acks = 0;
        for (int c = 0; c < 8; c++) begin
            #1 step();
            if (cpu_ack || dma_ack) acks++;
            @(negedge clk);
        end
        check32("abort_no_ack", 32'(acks), 32'd0);
        txn(0, 0, 32'd1032, 32'd0, lat, rd, er);
        check32("abort_no_write", rd, 32'd0);

        // Simultaneous held requests right after reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'd1024;
        dma_req = 1; dma_we = 0; dma_addr = 32'd1028;
        for (int c = 0; c < 40 && seq.size() < 3; c++) begin
            #1 step();
            if (cpu_ack) seq.push_back(0);
            if (dma_ack) seq.push_back(1);
            @(negedge clk);
        end
`ifdef DMEM_ARB_RR_EN
        exp_seq = '{0, 1, 0};
`else
        exp_seq = '{0, 0, 0};
`endif
        check32("arb_count", 32'(seq.size()), 32'd3);
        for (int i = 0; i < 3 && i < seq.size(); i++) begin
            check32($sformatf("arb_grant%0d", i), 32'(seq[i]), 32'(exp_seq[i]));
        end
        cpu_req = 0; dma_req = 0;
        tick();
        tick();
        tick();

        // Randomized traffic on both ports.
        for (int n = 0; n < 1500; n++) begin
            rst = 1'b0;
            if (cpu_req && e_cpu_ack) begin
                if ($urandom_range(1, 0) == 1) begin
                    cpu_we = 1'($urandom_range(1, 0)); cpu_addr = rand_addr(); cpu_wdata = $urandom;
                end else begin
                    cpu_req = 1'b0;
                end
            end else if (!cpu_req && $urandom_range(2, 0) == 0) begin
                cpu_req = 1'b1; cpu_we = 1'($urandom_range(1, 0)); cpu_addr = rand_addr(); cpu_wdata = $urandom;
            end
            if (dma_req && e_dma_ack) begin
                if ($urandom_range(1, 0) == 1) begin
                    dma_we = 1'($urandom_range(1, 0)); dma_addr = rand_addr(); dma_wdata = $urandom;
                end else begin
                    dma_req = 1'b0;
                end
            end else if (!dma_req && $urandom_range(2, 0) == 0) begin
                dma_req = 1'b1; dma_we = 1'($urandom_range(1, 0)); dma_addr = rand_addr(); dma_wdata = $urandom;
            end
            if ($urandom_range(299, 0) == 0) rst = 1'b1;
            tick();
        end
        rst = 1'b0; cpu_req = 0; dma_req = 0;
        tick();

        // Zero wait states, DMA read held high: IDLE, ACCESS, RESP repeating.
        z_dma_req = 1'b1;
        for (int c = 0; c < 9; c++) begin
            #1;
            check32($sformatf("z_busy_c%0d", c), {31'd0, z_busy}, {31'd0, (c % 3) != 0});
            check32($sformatf("z_ack_c%0d", c), {31'd0, z_dma_ack}, {31'd0, (c % 3) == 2});
            step();
            @(negedge clk);
        end
        z_dma_req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
